// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares a single-port 1-cycle-latency RAM between the fetch unit
//            and the load/store unit. Data has priority with a bounded fetch
//            starvation count; define MEM_ARB_ROUND_ROBIN_EN for alternating
//            priority on conflicts instead.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_async,
  input  logic        fetch_req,
  input  logic [12:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [15:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [12:0] data_addr,
  input  logic [1:0]  data_be,
  input  logic [15:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [15:0] data_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  owner_t resp_owner;
  owner_t resp_owner_nxt;
  logic   fetch_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when fetch took the last grant; reset as if fetch won so data wins first.
  logic last_fetch;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      last_fetch <= 1'b1;
    end else if (fetch_gnt) begin
      last_fetch <= 1'b1;
    end else if (data_gnt) begin
      last_fetch <= 1'b0;
    end
  end

  always_comb begin
    fetch_win = fetch_req && (!data_req || !last_fetch);
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      starve_cnt <= 4'd0;
    end else if (!fetch_req || fetch_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    fetch_win = fetch_req && (!data_req || (starve_cnt == LIMIT));
  end
`endif

  always_comb begin
    fetch_gnt = fetch_win && !rst_async;
    data_gnt  = data_req && !fetch_win && !rst_async;
  end

  always_comb begin
    mem_addr  = fetch_addr;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    mem_wdata = data_wdata;
    if (data_gnt) begin
      mem_addr = data_addr;
      mem_we   = data_we;
      mem_be   = data_we ? data_be : 2'b00;
    end
  end

  // Writes produce no response, so only reads claim the return slot.
  always_comb begin
    resp_owner_nxt = OWN_NONE;
    if (fetch_gnt) begin
      resp_owner_nxt = OWN_FETCH;
    end else if (data_gnt && !data_we) begin
      resp_owner_nxt = OWN_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= resp_owner_nxt;
    end
  end

  always_comb begin
    fetch_rvalid = (resp_owner == OWN_FETCH);
    data_rvalid  = (resp_owner == OWN_DATA);
    fetch_rdata  = mem_rdata;
    data_rdata   = mem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scoreboard bench for mem_port_arbiter with a write-first
//            RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int O_NONE  = 0;
  localparam int O_FETCH = 1;
  localparam int O_DATA  = 2;

  typedef struct {
    int          owner;
    logic [15:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        fetch_req;
  logic [12:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [12:0] data_addr;
  logic [1:0]  data_be;
  logic [15:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [15:0] data_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  resp_t       q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] ram [8192];
  logic        ram_init;
  logic [15:0] ram_word;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_async    (rst_async),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_be      (data_be),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [15:0] init_word(input logic [12:0] a);
    return (a == 13'h0010) ? 16'h1234 : ({3'b000, a} ^ 16'hA5A5);
  endfunction

  function automatic logic [15:0] exp_word(input logic [12:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  // Write-first synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8192; i++) ram[i] <= init_word(13'(i));
      mem_rdata <= 16'h0000;
    end else begin
      ram_word = ram[mem_addr];
      if (mem_we) begin
        if (mem_be[0]) ram_word[7:0]  = mem_wdata[7:0];
        if (mem_be[1]) ram_word[15:8] = mem_wdata[15:8];
        ram[mem_addr] <= ram_word;
      end
      mem_rdata <= ram_word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: check the response due now, check this cycle's grants and
  // memory drive, then queue the response owed next cycle.
  task automatic step(input logic ef, input logic ed);
    resp_t e;
    resp_t n;
    logic [15:0] w;
    @(negedge clk);
    if (q.size() == 0) begin
      e.owner = O_NONE;
      e.data  = 16'h0;
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
    end
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e.owner == O_FETCH));
    chk("data_rvalid", 32'(data_rvalid), 32'(e.owner == O_DATA));
    if (e.owner == O_FETCH) chk("fetch_rdata", 32'(fetch_rdata), 32'(e.data));
    if (e.owner == O_DATA)  chk("data_rdata", 32'(data_rdata), 32'(e.data));
    chk("fetch_gnt", 32'(fetch_gnt), 32'(ef));
    chk("data_gnt", 32'(data_gnt), 32'(ed));
    n.owner = O_NONE;
    n.data  = 16'h0;
    if (ef) begin
      chk("f_mem_addr", 32'(mem_addr), 32'(fetch_addr));
      chk("f_mem_we", 32'(mem_we), 32'd0);
      chk("f_mem_be", 32'(mem_be), 32'd0);
      n.owner = O_FETCH;
      n.data  = exp_word(fetch_addr);
    end else if (ed) begin
      chk("d_mem_addr", 32'(mem_addr), 32'(data_addr));
      chk("d_mem_we", 32'(mem_we), 32'(data_we));
      chk("d_mem_be", 32'(mem_be), data_we ? 32'(data_be) : 32'd0);
      if (data_we) begin
        chk("d_mem_wdata", 32'(mem_wdata), 32'(data_wdata));
        w = exp_word(data_addr);
        if (data_be[0]) w[7:0]  = data_wdata[7:0];
        if (data_be[1]) w[15:8] = data_wdata[15:8];
        ref_mem[int'(data_addr)] = w;
      end else begin
        n.owner = O_DATA;
        n.data  = exp_word(data_addr);
      end
    end else begin
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_mem_be", 32'(mem_be), 32'd0);
    end
    q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic push_none();
    resp_t n;
    n.owner = O_NONE;
    n.data  = 16'h0;
    q.push_back(n);
  endtask

  initial begin
    rst_async  = 1'b1;
    ram_init   = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 13'h0005;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = 13'h0;
    data_be    = 2'b00;
    data_wdata = 16'h0;
    @(posedge clk);
    #1 ram_init = 1'b0;
    @(negedge clk);
    chk("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst_data_rvalid", 32'(data_rvalid), 32'd0);
    @(posedge clk);
    #1 rst_async = 1'b0;
    fetch_req = 1'b0;
    push_none();

    // Lone fetch read
    fetch_req = 1'b1; fetch_addr = 13'h0005;
    step(1'b1, 1'b0);
    fetch_req = 1'b0;
    step(1'b0, 1'b0);

    // Byte-enabled write then read-back of the same word
    data_req = 1'b1; data_we = 1'b1; data_addr = 13'h0010; data_be = 2'b01; data_wdata = 16'hABCD;
    step(1'b0, 1'b1);
    data_we = 1'b0;
    step(1'b0, 1'b1);
    data_req = 1'b0;
    step(1'b0, 1'b0);

    // Reset while a fetch response is in flight
    fetch_req = 1'b1; fetch_addr = 13'h0007;
    step(1'b1, 1'b0);
    rst_async = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    @(negedge clk);
    chk("mid_rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("mid_rst_data_rvalid", 32'(data_rvalid), 32'd0);
    @(posedge clk);
    #1 rst_async = 1'b0;
    push_none();

    // Continuous conflict from a fresh reset
    fetch_addr = 13'h0100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 13'h0200;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if ((i % 2) == 0) begin
`else
      if ((i % 5) != 4) begin
`endif
        step(1'b0, 1'b1);
        data_addr = data_addr + 13'd1;
      end else begin
        step(1'b1, 1'b0);
        fetch_addr = fetch_addr + 13'd1;
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    step(1'b0, 1'b0);

    // Write in cycle N, fetch in N+1: only the fetch response appears
    data_req = 1'b1; data_we = 1'b1; data_addr = 13'h0020; data_be = 2'b11; data_wdata = 16'h5AC3;
    step(1'b0, 1'b1);
    data_req = 1'b0; data_we = 1'b0;
    fetch_req = 1'b1; fetch_addr = 13'h0020;
    step(1'b1, 1'b0);
    fetch_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
